digit_scan_mux: RTL and testbench
=================================

// Module: digit_scan_mux
// PURPOSE
//  - Upstream feeder for the per-segment 7-seg decoders. Time-multiplexes a 16-bit value (4 hex digits) onto one 4-bit nibble bus.
//  - Drives active-low digit anodes and a blank flag for the segment drivers.
//  - Double-buffers the incoming value so a displayed frame never tears.
//  - Optionally suppresses leading zeros.
// PARAMETERS
//  DWELL_CYCLES  50000  clocks per digit slot (1 kHz/digit @ 50 MHz); legal range 4..2^20
//  GAP_CYCLES    500    anti-ghost blanking clocks at start of each slot; must be < DWELL_CYCLES
// PORTS
//  JM1222HM_clk     in   1   single system clock, rising edge
//  JM1222HM_rst_n   in   1   asynchronous, active-low reset
//  JM1222HM_en      in   1   scan enable; low = hold counters, display dark
//  JM1222HM_load    in   1   1-cycle strobe: capture JM1222HM_value into shadow
//  JM1222HM_value   in   16  [15:12]=digit3 (MS) .. [3:0]=digit0 (LS)
//  JM1222HM_blz     in   1   1 = leading-zero blanking on
//  JM1222HM_nib     out  4   current digit nibble; bit3 -> decoder in1, bit0 -> decoder in4
//  JM1222HM_an_n    out  4   anode enables, active-low, one-hot-low or all 1
//  JM1222HM_blank   out  1   1 = segment decoders must drive segments off
//  JM1222HM_frame   out  1   1-cycle pulse when shadow is committed to display
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - nib=0, an_n=4'b1111, blank=1, frame=0.
//    - Internal state: slot counter=0, digit idx=0, shadow=0, disp=0, pending=0.
//  - Slot counter:
//    - Increments 0..DWELL_CYCLES-1 when en=1.
//    - At DWELL_CYCLES-1 it wraps to 0 and the digit idx advances 0->1->2->3->0.
//  - Phases within a slot:
//    - GAP phase: count < GAP_CYCLES.
//    - SHOW phase: count >= GAP_CYCLES.
//  - Outputs are registered, one clock after the counter/idx they reflect:
//    - GAP phase: an_n=1111, blank=1, nib=disp digit[idx].
//    - SHOW phase: an_n[idx]=0, others 1; nib=disp digit[idx]; blank=lz(idx).
//  - Leading-zero function lz(i):
//    - lz(i)=1 iff blz=1, i>0, and disp digits i..3 are all zero.
//    - Digit 0 is never blanked. Value 0 shows a single "0".
//    - In a blanked SHOW slot, an_n still selects idx; blank=1 turns segments off.
//  - load:
//    - On load=1: shadow<=value, pending<=1. Back-to-back loads: last one wins.
//  - Commit:
//    - Happens on the edge where idx wraps 3->0 with en=1 and pending=1.
//    - disp<=shadow and frame=1 on the next cycle.
//    - pending clears unless load=1 on that same edge.
//    - Same-edge load: commit uses the pre-edge shadow; the new value is captured and stays pending for the next frame.
//  - en=0:
//    - Counter and idx hold; an_n=1111, blank=1 from the next cycle.
//    - load is still accepted; no commit occurs.
//    - Resuming en=1 continues from the held count.
//  - Reset mid-slot or mid-frame: immediate return to reset values; the pending value is lost.
//  - Latency from load to first visible new digit: up to 4*DWELL_CYCLES + 2 clocks.
// STRUCTURE
//  - Shared package/include calc_disp_pkg holds:
//    - NUM_DIGITS=4, IDX_W=2, NIB_W=4.
//    - AN_OFF=4'b1111.
//    - Function onehot_low(idx) returning the anode pattern.
//  - One sub-module, disp_slot_timer:
//    - Parameterised slot counter plus idx counter.
//    - Outputs: idx, in_gap, slot_end, frame_end.
//  - Top level holds shadow/disp/pending, lz logic and output registers.
// TESTING (DWELL_CYCLES=8, GAP_CYCLES=2 for all directed tests)
//  1. Reset then en=1, no load:
//     - an_n=1111 for 2 clocks, then 1110 for 6 clocks, nib=0, blank=0, idx cycles every 8 clocks.
//  2. load value=16'h12AF, then wait for the frame boundary:
//     - frame pulses once.
//     - SHOW slots give nib F,A,2,1 with an_n 1110,1101,1011,0111.
//  3. blz=1, value=16'h0030:
//     - digit0 nib=0, blank=0; digit1 nib=3, blank=0.
//     - digits 2,3 blank=1. With value=0, only digit0 is unblanked.
//  4. load 16'h1111 on the exact 3->0 wrap edge while 16'h2222 is pending:
//     - the 2222 frame commits first, frame pulses, pending stays 1.
//     - 1111 commits at the next wrap.
//  5. Drop en for 5 clocks in mid-SHOW of digit 2:
//     - an_n=1111, blank=1 during the drop.
//     - On resume, digit 2 shows for its remaining count; total slot = 8 enabled clocks.
//  6. Assert rst_n=0 asynchronously mid-slot with pending=1:
//     - outputs hit reset values without a clock edge.
//     - after release, disp=0 and no frame pulse occurs.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared constants and helpers for the 4-digit hex display scan path.
package calc_disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;
  localparam int NIB_W      = 4;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  // Active-low one-hot anode pattern selecting digit idx.
  function automatic logic [NUM_DIGITS-1:0] onehot_low(input logic [IDX_W-1:0] idx);
    onehot_low = ~(NUM_DIGITS'(1) << idx);
  endfunction
endpackage

// File: rtl/disp_slot_timer.sv
// Slot dwell counter plus digit index; both freeze while en is low.
module disp_slot_timer
  import calc_disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             in_gap,
  output logic             slot_end,
  output logic             frame_end
);
  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  assign cnt_last  = (cnt == CNT_W'(DWELL_CYCLES - 1));
  assign in_gap    = (cnt < CNT_W'(GAP_CYCLES));
  assign slot_end  = en & cnt_last;
  assign frame_end = slot_end & (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (cnt_last) begin
        cnt <= '0;
        idx <= idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed 4-digit nibble/anode driver with double-buffered value
// and optional leading-zero blanking.
module digit_scan_mux
  import calc_disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500
) (
  input  logic                  JM1222HM_clk,
  input  logic                  JM1222HM_rst_n,
  input  logic                  JM1222HM_en,
  input  logic                  JM1222HM_load,
  input  logic [15:0]           JM1222HM_value,
  input  logic                  JM1222HM_blz,
  output logic [NIB_W-1:0]      JM1222HM_nib,
  output logic [NUM_DIGITS-1:0] JM1222HM_an_n,
  output logic                  JM1222HM_blank,
  output logic                  JM1222HM_frame
);
  logic [IDX_W-1:0] idx;
  logic             in_gap;
  logic             slot_end;
  logic             frame_end;

  disp_slot_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_timer (
    .clk       (JM1222HM_clk),
    .rst_n     (JM1222HM_rst_n),
    .en        (JM1222HM_en),
    .idx       (idx),
    .in_gap    (in_gap),
    .slot_end  (slot_end),
    .frame_end (frame_end)
  );

  logic [NUM_DIGITS-1:0][NIB_W-1:0] shadow;
  logic [NUM_DIGITS-1:0][NIB_W-1:0] disp;
  logic                             pending;
  logic                             commit;
  logic                             upper_zero;
  logic                             lz_cur;

  // Swap buffers only at the frame boundary so a frame never mixes values.
  assign commit = frame_end & pending;

  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((IDX_W'(k) >= idx) && (disp[k] != '0)) upper_zero = 1'b0;
    end
  end

  // Digit 0 is never blanked so a zero value still shows one "0".
  assign lz_cur = JM1222HM_blz & (idx != '0) & upper_zero;

  always_ff @(posedge JM1222HM_clk or negedge JM1222HM_rst_n) begin
    if (!JM1222HM_rst_n) begin
      shadow         <= '0;
      disp           <= '0;
      pending        <= 1'b0;
      JM1222HM_nib   <= '0;
      JM1222HM_an_n  <= AN_OFF;
      JM1222HM_blank <= 1'b1;
      JM1222HM_frame <= 1'b0;
    end else begin
      if (JM1222HM_load) shadow <= JM1222HM_value;
      if (commit)        disp   <= shadow;
      pending        <= JM1222HM_load | (pending & ~commit);
      JM1222HM_frame <= commit;
      JM1222HM_nib   <= disp[idx];
      if (!JM1222HM_en || in_gap) begin
        JM1222HM_an_n  <= AN_OFF;
        JM1222HM_blank <= 1'b1;
      end else begin
        JM1222HM_an_n  <= onehot_low(idx);
        JM1222HM_blank <= lz_cur;
      end
    end
  end
endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux with an 8-clock slot and 2-clock gap.
module tb_digit_scan_mux;
  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        blz;
  logic [3:0]  nib;
  logic [3:0]  an_n;
  logic        blank;
  logic        frame;

  int n_vec = 0;
  int n_err = 0;

  digit_scan_mux #(
    .DWELL_CYCLES (8),
    .GAP_CYCLES   (2)
  ) dut (
    .JM1222HM_clk   (clk),
    .JM1222HM_rst_n (rst_n),
    .JM1222HM_en    (en),
    .JM1222HM_load  (load),
    .JM1222HM_value (value),
    .JM1222HM_blz   (blz),
    .JM1222HM_nib   (nib),
    .JM1222HM_an_n  (an_n),
    .JM1222HM_blank (blank),
    .JM1222HM_frame (frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ld_first;
    logic        ld_last;
    logic [15:0] ld_val;
    logic        blz;
    logic [3:0]  an;
    logic [3:0]  nib;
    logic        blank;
    logic        frame;
  } slot_t;

  slot_t tbl[28];

  function automatic slot_t mk(input logic ldf, input logic ldl, input logic [15:0] v,
                               input logic b, input int s, input logic [3:0] n,
                               input logic bl, input logic fr);
    slot_t r;
    logic [3:0] pat [4];
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
    r.ld_first = ldf; r.ld_last = ldl; r.ld_val = v; r.blz = b;
    r.an = pat[s]; r.nib = n; r.blank = bl; r.frame = fr;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_slot(input int id);
    slot_t r;
    logic  gap;
    r   = tbl[id];
    blz = r.blz;
    for (int e = 0; e < 8; e++) begin
      load  = (e == 0 && r.ld_first) || (e == 7 && r.ld_last);
      value = r.ld_val;
      step();
      load = 1'b0;
      gap  = (e < 2);
      chk($sformatf("slot%0d.e%0d an_n", id, e), {12'h0, an_n}, {12'h0, gap ? 4'b1111 : r.an});
      chk($sformatf("slot%0d.e%0d nib", id, e), {12'h0, nib}, {12'h0, r.nib});
      chk($sformatf("slot%0d.e%0d blank", id, e), {15'h0, blank}, {15'h0, gap ? 1'b1 : r.blank});
      chk($sformatf("slot%0d.e%0d frame", id, e), {15'h0, frame}, {15'h0, (e == 7) ? r.frame : 1'b0});
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " nib"},   {12'h0, nib},   16'h0);
    chk({tag, " an_n"},  {12'h0, an_n},  16'h000F);
    chk({tag, " blank"}, {15'h0, blank}, 16'h1);
    chk({tag, " frame"}, {15'h0, frame}, 16'h0);
  endtask

  initial begin
    // frame 0: display still 0, 12AF queued
    tbl[0]  = mk(1, 0, 16'h12AF, 0, 0, 4'h0, 0, 0);
    tbl[1]  = mk(0, 0, 16'h0000, 0, 1, 4'h0, 0, 0);
    tbl[2]  = mk(0, 0, 16'h0000, 0, 2, 4'h0, 0, 0);
    tbl[3]  = mk(0, 0, 16'h0000, 0, 3, 4'h0, 0, 1);
    // frame 1: 12AF visible, 0030 queued
    tbl[4]  = mk(0, 0, 16'h0000, 0, 0, 4'hF, 0, 0);
    tbl[5]  = mk(0, 0, 16'h0000, 0, 1, 4'hA, 0, 0);
    tbl[6]  = mk(1, 0, 16'h0030, 0, 2, 4'h2, 0, 0);
    tbl[7]  = mk(0, 0, 16'h0000, 0, 3, 4'h1, 0, 1);
    // frame 2: 0030 with leading-zero blanking, 0000 queued
    tbl[8]  = mk(0, 0, 16'h0000, 1, 0, 4'h0, 0, 0);
    tbl[9]  = mk(0, 0, 16'h0000, 1, 1, 4'h3, 0, 0);
    tbl[10] = mk(0, 0, 16'h0000, 1, 2, 4'h0, 1, 0);
    tbl[11] = mk(1, 0, 16'h0000, 1, 3, 4'h0, 1, 1);
    // frame 3: value 0 shows only digit 0; 2222 queued, 1111 loaded on the wrap edge
    tbl[12] = mk(0, 0, 16'h0000, 1, 0, 4'h0, 0, 0);
    tbl[13] = mk(1, 0, 16'h2222, 1, 1, 4'h0, 1, 0);
    tbl[14] = mk(0, 0, 16'h0000, 1, 2, 4'h0, 1, 0);
    tbl[15] = mk(0, 1, 16'h1111, 1, 3, 4'h0, 1, 1);
    // frame 4: 2222 visible, 1111 still pending
    tbl[16] = mk(0, 0, 16'h0000, 0, 0, 4'h2, 0, 0);
    tbl[17] = mk(0, 0, 16'h0000, 0, 1, 4'h2, 0, 0);
    tbl[18] = mk(0, 0, 16'h0000, 0, 2, 4'h2, 0, 0);
    tbl[19] = mk(0, 0, 16'h0000, 0, 3, 4'h2, 0, 1);
    // frame 5: 1111 visible, nothing pending
    tbl[20] = mk(0, 0, 16'h0000, 0, 0, 4'h1, 0, 0);
    tbl[21] = mk(0, 0, 16'h0000, 0, 1, 4'h1, 0, 0);
    tbl[22] = mk(0, 0, 16'h0000, 0, 2, 4'h1, 0, 0);
    tbl[23] = mk(0, 0, 16'h0000, 0, 3, 4'h1, 0, 0);
    // frame after mid-slot reset: pending value lost, no commit
    tbl[24] = mk(0, 0, 16'h0000, 0, 0, 4'h0, 0, 0);
    tbl[25] = mk(0, 0, 16'h0000, 0, 1, 4'h0, 0, 0);
    tbl[26] = mk(0, 0, 16'h0000, 0, 2, 4'h0, 0, 0);
    tbl[27] = mk(0, 0, 16'h0000, 0, 3, 4'h0, 0, 0);

    rst_n = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0; blz = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    chk_reset_outs("por");
    rst_n = 1'b1;
    en    = 1'b1;

    for (int i = 0; i < 24; i++) run_slot(i);

    // en drop in mid-SHOW of digit 2 (display holds 1111)
    repeat (16) step();
    repeat (4) step();
    chk("pre-drop an_n", {12'h0, an_n}, 16'h000B);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("drop%0d an_n", i), {12'h0, an_n}, 16'h000F);
      chk($sformatf("drop%0d blank", i), {15'h0, blank}, 16'h1);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("resume%0d an_n", i), {12'h0, an_n}, 16'h000B);
      chk($sformatf("resume%0d nib", i), {12'h0, nib}, 16'h0001);
      chk($sformatf("resume%0d blank", i), {15'h0, blank}, 16'h0);
    end
    step();
    chk("slot3 gap0 an_n", {12'h0, an_n}, 16'h000F);
    step();
    chk("slot3 gap1 an_n", {12'h0, an_n}, 16'h000F);
    step();
    chk("slot3 show an_n", {12'h0, an_n}, 16'h0007);

    // async reset mid-slot with a load pending
    load  = 1'b1;
    value = 16'h5555;
    step();
    load = 1'b0;
    chk("pre-reset an_n", {12'h0, an_n}, 16'h0007);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outs("async");
    #2 rst_n = 1'b1;
    for (int i = 24; i < 28; i++) run_slot(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
